// File: rtl/arbitro_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encodings, the
// requester count and the default data width.
package arbitro_pkg;

  localparam int N_REQ         = 4;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CARICA   = 2'd1,
    TIENI    = 2'd2,
    RILASCIO = 2'd3
  } stato_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/selettore_round_robin.sv
// Combinational round-robin search: first requesting index at or after ptr,
// wrapping 3->0.
module selettore_round_robin
  import arbitro_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       winner,
  output logic             valid
);

  // Scanning from the farthest offset down lets the nearest requester win.
  always_comb begin
    logic [1:0] idx;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = ptr + 2'(off);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_registro_condiviso.sv
// Round-robin arbiter granting one requester at a time the right to load a
// shared register; all state moves on the falling edge of ck.
module arbitro_registro_condiviso #(
  parameter int WIDTH       = arbitro_pkg::WIDTH_DEFAULT,
  parameter int N_REQ       = arbitro_pkg::N_REQ,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   ck,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] dati_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic [1:0]             proprietario,
  output logic                   valido
);

  import arbitro_pkg::*;

  if (N_REQ != 4) begin : g_bad_n_req
    $error("arbitro_registro_condiviso supports only N_REQ = 4");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("arbitro_registro_condiviso: HOLD_CYCLES must be 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(HOLD_CYCLES - 1);

  stato_t           stato, stato_n;
  logic [1:0]       ptr, ptr_n;
  logic [3:0]       cnt, cnt_n;
  logic [N_REQ-1:0] gnt_n;
  logic [WIDTH-1:0] q_n;
  logic [1:0]       prop_n;
  logic             valido_n;
  logic [1:0]       sel_winner;
  logic             sel_valid;

  selettore_round_robin u_selettore (
    .req    (req),
    .ptr    (ptr),
    .winner (sel_winner),
    .valid  (sel_valid)
  );

  // proprietario doubles as the latched winner for the whole grant.
  always_comb begin
    stato_n  = stato;
    ptr_n    = ptr;
    cnt_n    = cnt;
    gnt_n    = gnt;
    q_n      = q;
    prop_n   = proprietario;
    valido_n = valido;
    case (stato)
      IDLE: begin
        if (sel_valid) begin
          stato_n = CARICA;
          gnt_n   = onehot(sel_winner);
          prop_n  = sel_winner;
        end
      end
      CARICA: begin
        if (req[proprietario]) begin
          q_n      = dati_in[int'(proprietario)*WIDTH +: WIDTH];
          valido_n = 1'b1;
          cnt_n    = CNT_INIT;
          stato_n  = TIENI;
        end else begin
          gnt_n   = '0;
          ptr_n   = proprietario + 2'd1;
          stato_n = IDLE;
        end
      end
      TIENI: begin
        if (!req[proprietario]) begin
          gnt_n   = '0;
          ptr_n   = proprietario + 2'd1;
          stato_n = IDLE;
        end else if (cnt == 4'd0) begin
          stato_n = RILASCIO;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RILASCIO: begin
        gnt_n   = '0;
        ptr_n   = proprietario + 2'd1;
        stato_n = IDLE;
      end
      default: stato_n = IDLE;
    endcase
  end

  always_ff @(negedge ck) begin
    if (reset) begin
      stato        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      gnt          <= '0;
      q            <= '0;
      proprietario <= '0;
      valido       <= 1'b0;
    end else begin
      stato        <= stato_n;
      ptr          <= ptr_n;
      cnt          <= cnt_n;
      gnt          <= gnt_n;
      q            <= q_n;
      proprietario <= prop_n;
      valido       <= valido_n;
    end
  end

endmodule
